// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared definitions for the pipeline stall controller: FSM state encoding,
//   register-index width and the multi-cycle-op timeout limit.
//   Configuration macro used by the top level: STALL_COUNTER_EN.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LU_FWD  = 2'd1,
    MD_WAIT = 2'd2
  } state_t;

  localparam int REG_W     = 5;
  localparam int MD_CNT_W  = 6;

  localparam int unsigned MD_TIMEOUT_LIMIT = 34;
  localparam logic [MD_CNT_W-1:0] MD_LIMIT_CNT = MD_CNT_W'(MD_TIMEOUT_LIMIT);

endpackage

// File: rtl/hazard_compare.sv
// hazard_compare
//   Load-use hazard detection between the load in ID/EX and the sources of
//   the instruction in decode.
//   Ports:
//     LOAD_SIG      in   ID/EX instruction is a load
//     EX_RD         in   5  load destination register
//     ID_RS1/RS2    in   5  decode-stage source registers
//     ID_USES_RS1/2 in   1  source valid flags
//     RS1_MATCH     out  load writes a register that rs1 reads
//     RS2_MATCH     out  load writes a register that rs2 reads
//     LU            out  load-use hazard present
module hazard_compare
  import hazard_ctrl_pkg::*;
(
  input  logic             LOAD_SIG,
  input  logic [REG_W-1:0] EX_RD,
  input  logic [REG_W-1:0] ID_RS1,
  input  logic [REG_W-1:0] ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  output logic             RS1_MATCH,
  output logic             RS2_MATCH,
  output logic             LU
);

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  logic ex_rd_live;
  assign ex_rd_live = LOAD_SIG & (EX_RD != '0);

  assign RS1_MATCH = ex_rd_live & ID_USES_RS1 & (EX_RD == ID_RS1);
  assign RS2_MATCH = ex_rd_live & ID_USES_RS2 & (EX_RD == ID_RS2);
  assign LU        = RS1_MATCH | RS2_MATCH;

endmodule

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Central stall/flush/forwarding control for a 5-stage pipeline: load-use
//   stalls with WB forwarding, branch flushes, multi-cycle mul/div waits with
//   a sticky timeout, and a global data-memory-busy freeze.
//   Optional feature: define STALL_COUNTER_EN to add the STALL_COUNT output.
//   Ports:
//     CLK, RESET                      in   clock, synchronous active-high reset
//     LOAD_SIG, EX_RD                 in   load in ID/EX and its destination
//     ID_RS1, ID_RS2, ID_USES_RS1/2   in   decode sources and valid flags
//     BRANCH_TAKEN                    in   EX-stage redirect
//     MULDIV_START, MULDIV_DONE       in   multi-cycle op start / result ready
//     DMEM_BUSY                       in   data memory not ready
//     PC_EN, IF_ID_EN, ID_EX_EN, EX_MEM_EN  out  pipeline register enables
//     IF_ID_FLUSH, ID_EX_FLUSH        out  flushes (ID_EX_FLUSH = bubble)
//     FRWD_RS1_WB, FRWD_RS2_WB        out  select WB-stage forwarding
//     STALL_COUNT                     out  32  cycles with PC_EN=0 (optional)
//     MULDIV_TIMEOUT                  out  sticky mul/div timeout error
module pipeline_stall_controller
  import hazard_ctrl_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             LOAD_SIG,
  input  logic [REG_W-1:0] EX_RD,
  input  logic [REG_W-1:0] ID_RS1,
  input  logic [REG_W-1:0] ID_RS2,
  input  logic             ID_USES_RS1,
  input  logic             ID_USES_RS2,
  input  logic             BRANCH_TAKEN,
  input  logic             MULDIV_START,
  input  logic             MULDIV_DONE,
  input  logic             DMEM_BUSY,
  output logic             PC_EN,
  output logic             IF_ID_EN,
  output logic             ID_EX_EN,
  output logic             EX_MEM_EN,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_FLUSH,
  output logic             FRWD_RS1_WB,
  output logic             FRWD_RS2_WB,
`ifdef STALL_COUNTER_EN
  output logic [31:0]      STALL_COUNT,
`endif
  output logic             MULDIV_TIMEOUT
);

  state_t              state, state_d;
  logic                rs1_flag, rs1_flag_d;
  logic                rs2_flag, rs2_flag_d;
  logic [MD_CNT_W-1:0] md_cnt, md_cnt_d, md_cnt_inc;
  logic                md_timeout_d;
  logic                rs1_match, rs2_match, lu;

  hazard_compare u_compare (
    .LOAD_SIG    (LOAD_SIG),
    .EX_RD       (EX_RD),
    .ID_RS1      (ID_RS1),
    .ID_RS2      (ID_RS2),
    .ID_USES_RS1 (ID_USES_RS1),
    .ID_USES_RS2 (ID_USES_RS2),
    .RS1_MATCH   (rs1_match),
    .RS2_MATCH   (rs2_match),
    .LU          (lu)
  );

  assign md_cnt_inc = (md_cnt == '1) ? md_cnt : md_cnt + 6'd1;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state          <= RUN;
      rs1_flag       <= 1'b0;
      rs2_flag       <= 1'b0;
      md_cnt         <= '0;
      MULDIV_TIMEOUT <= 1'b0;
    end else begin
      state          <= state_d;
      rs1_flag       <= rs1_flag_d;
      rs2_flag       <= rs2_flag_d;
      md_cnt         <= md_cnt_d;
      MULDIV_TIMEOUT <= md_timeout_d;
    end
  end

  always_comb begin
    PC_EN        = 1'b1;
    IF_ID_EN     = 1'b1;
    ID_EX_EN     = 1'b1;
    EX_MEM_EN    = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_FLUSH  = 1'b0;
    // Forwarding depends only on state and latched flags, so it naturally
    // holds its value while DMEM_BUSY freezes the FSM.
    FRWD_RS1_WB  = (state == LU_FWD) & rs1_flag;
    FRWD_RS2_WB  = (state == LU_FWD) & rs2_flag;
    state_d      = state;
    rs1_flag_d   = rs1_flag;
    rs2_flag_d   = rs2_flag;
    md_cnt_d     = md_cnt;
    md_timeout_d = MULDIV_TIMEOUT;

    if (RESET) begin
      PC_EN       = 1'b0;
      IF_ID_EN    = 1'b0;
      ID_EX_EN    = 1'b0;
      EX_MEM_EN   = 1'b0;
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
      FRWD_RS1_WB = 1'b0;
      FRWD_RS2_WB = 1'b0;
    end else if (DMEM_BUSY) begin
      PC_EN     = 1'b0;
      IF_ID_EN  = 1'b0;
      ID_EX_EN  = 1'b0;
      EX_MEM_EN = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (MULDIV_START) begin
            state_d  = MD_WAIT;
            md_cnt_d = '0;
          end else if (lu) begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_FLUSH = 1'b1;
            rs1_flag_d  = rs1_match;
            rs2_flag_d  = rs2_match;
            state_d     = LU_FWD;
          end
        end
        LU_FWD: begin
          // The forwarding cycle still honours a redirect, and a fresh
          // load-use hazard stalls again with newly latched flags.
          state_d = RUN;
          if (BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (lu) begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_EX_FLUSH = 1'b1;
            rs1_flag_d  = rs1_match;
            rs2_flag_d  = rs2_match;
            state_d     = LU_FWD;
          end
        end
        MD_WAIT: begin
          PC_EN     = 1'b0;
          IF_ID_EN  = 1'b0;
          ID_EX_EN  = 1'b0;
          EX_MEM_EN = 1'b0;
          if (MULDIV_DONE) begin
            PC_EN     = 1'b1;
            IF_ID_EN  = 1'b1;
            ID_EX_EN  = 1'b1;
            EX_MEM_EN = 1'b1;
            state_d   = RUN;
          end else begin
            md_cnt_d = md_cnt_inc;
            // Timeout fires on the wait cycle that brings the count to the limit.
            if (md_cnt_inc >= MD_LIMIT_CNT) begin
              md_timeout_d = 1'b1;
              state_d      = RUN;
            end
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

`ifdef STALL_COUNTER_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      STALL_COUNT <= '0;
    end else if (!PC_EN && (STALL_COUNT != 32'hFFFF_FFFF)) begin
      STALL_COUNT <= STALL_COUNT + 32'd1;
    end
  end
`endif

endmodule
